// File: rtl/stream_mux2to1.sv
// Registered 2-to-1 stream merger: round-robin arbitration between two valid/ready
// inputs, source-tagged output beats and per-input accepted-beat counters.
module stream_mux2to1 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din0,
    input  logic             valid0,
    output logic             ready0,
    input  logic [WIDTH-1:0] din1,
    input  logic             valid1,
    output logic             ready1,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_src,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic [WIDTH-1:0] dout_r;
    logic             out_valid_r;
    logic             out_src_r;
    logic [CNT_W-1:0] cnt0_r;
    logic [CNT_W-1:0] cnt1_r;
    logic             last_grant_r;

    logic             grant_valid_s;
    logic             grant_idx_s;
    logic             can_accept_s;
    logic             xfer_s;

    // Round-robin grant: a tie goes to the channel that did not win last time.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        case ({valid1, valid0})
            2'b01: begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 1'b0;
            end
            2'b10: begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 1'b1;
            end
            2'b11: begin
                grant_valid_s = 1'b1;
                grant_idx_s   = ~last_grant_r;
            end
            default: begin
                grant_valid_s = 1'b0;
                grant_idx_s   = 1'b0;
            end
        endcase
    end

    // Handshake decode: accept only when the output register is empty or draining.
    always_comb begin
        can_accept_s = ~out_valid_r | out_ready;
        xfer_s       = grant_valid_s & can_accept_s & ~rst;
        ready0       = xfer_s & (grant_idx_s == 1'b0);
        ready1       = xfer_s & (grant_idx_s == 1'b1);
    end

    // Output register, arbitration history and beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            out_src_r    <= 1'b0;
            cnt0_r       <= {CNT_W{1'b0}};
            cnt1_r       <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;
        end else if (xfer_s) begin
            dout_r       <= grant_idx_s ? din1 : din0;
            out_src_r    <= grant_idx_s;
            out_valid_r  <= 1'b1;
            last_grant_r <= grant_idx_s;
            if (grant_idx_s) begin
                cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt0_r <= cnt0_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign dout      = dout_r;
    assign out_valid = out_valid_r;
    assign out_src   = out_src_r;
    assign cnt0      = cnt0_r;
    assign cnt1      = cnt1_r;

endmodule

// File: tb/tb_stream_mux2to1.sv
// Directed self-checking bench for stream_mux2to1: reset, round-robin, single
// channel, backpressure, counter wrap and mid-operation reset.
module tb_stream_mux2to1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din0, din1, dout;
    logic       valid0, valid1, ready0, ready1;
    logic       out_valid, out_ready, out_src;
    logic [7:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;

    stream_mux2to1 #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .din0(din0), .valid0(valid0), .ready0(ready0),
        .din1(din1), .valid1(valid1), .ready1(ready1),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
        .out_src(out_src), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid0 = 1'b1; valid1 = 1'b1; out_ready = 1'b1;
        din0 = 8'h00; din1 = 8'h00;

        // Reset held for two edges with both inputs offering
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ready0", ready0, 1'b0);
            check("rst_ready1", ready1, 1'b0);
            check("rst_valid", out_valid, 1'b0);
            check("rst_dout", dout, 8'h00);
            check("rst_cnt0", cnt0, 8'h00);
            check("rst_cnt1", cnt1, 8'h00);
        end

        // Release: first tie goes to channel 0, then strict alternation
        rst = 1'b0; din0 = 8'h11; din1 = 8'h22;
        #1;
        check("rel_ready0", ready0, 1'b1);
        check("rel_ready1", ready1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_dout", dout, (i % 2 == 0) ? 8'h11 : 8'h22);
            check("rr_src", out_src, (i % 2 == 0) ? 1'b0 : 1'b1);
            check("rr_valid", out_valid, 1'b1);
        end
        check("rr_cnt0", cnt0, 8'd2);
        check("rr_cnt1", cnt1, 8'd2);

        // Single channel beat then drain
        valid1 = 1'b0; din0 = 8'hA5;
        tick();
        check("single_dout", dout, 8'hA5);
        check("single_src", out_src, 1'b0);
        check("single_valid", out_valid, 1'b1);
        check("single_cnt0", cnt0, 8'd3);
        valid0 = 1'b0;
        tick();
        check("drain_valid", out_valid, 1'b0);
        check("drain_dout", dout, 8'hA5);

        // Backpressure: hold a ch1 beat while ch0 waits
        valid1 = 1'b1; din1 = 8'h33;
        tick();
        check("bp_load_dout", dout, 8'h33);
        check("bp_load_cnt1", cnt1, 8'd3);
        valid1 = 1'b0; valid0 = 1'b1; din0 = 8'h44; out_ready = 1'b0;
        #1;
        check("bp_ready0", ready0, 1'b0);
        check("bp_ready1", ready1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_dout", dout, 8'h33);
            check("bp_hold_src", out_src, 1'b1);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_ready0", ready0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready0", ready0, 1'b1);
        tick();
        check("bp_new_dout", dout, 8'h44);
        check("bp_new_src", out_src, 1'b0);
        check("bp_new_valid", out_valid, 1'b1);
        check("bp_cnt0", cnt0, 8'd4);

        // Counter wrap: 256 back-to-back ch0 beats starting from cnt0=4
        for (int i = 0; i < 252; i++) begin
            din0 = i[7:0];
            tick();
        end
        check("wrap_zero_cnt0", cnt0, 8'h00);
        check("wrap_dout", dout, 8'hFB);
        for (int i = 0; i < 4; i++) begin
            din0 = 8'hC0 + i[7:0];
            tick();
        end
        check("wrap_cnt0", cnt0, 8'd4);
        check("wrap_cnt1", cnt1, 8'd3);
        check("wrap_last_dout", dout, 8'hC3);

        // Mid-operation reset with a held beat and both inputs offering
        din0 = 8'h5A;
        tick();
        check("mid_load", dout, 8'h5A);
        valid0 = 1'b0; out_ready = 1'b0;
        tick();
        check("mid_hold_valid", out_valid, 1'b1);
        rst = 1'b1; valid0 = 1'b1; valid1 = 1'b1; din0 = 8'h66; din1 = 8'h77;
        #1;
        check("mid_rst_ready0", ready0, 1'b0);
        check("mid_rst_ready1", ready1, 1'b0);
        tick();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_dout", dout, 8'h00);
        check("mid_rst_cnt0", cnt0, 8'h00);
        check("mid_rst_cnt1", cnt1, 8'h00);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        check("mid_tie_ready0", ready0, 1'b1);
        check("mid_tie_ready1", ready1, 1'b0);
        tick();
        check("mid_tie_dout", dout, 8'h66);
        check("mid_tie_src", out_src, 1'b0);
        check("mid_tie_cnt0", cnt0, 8'd1);
        tick();
        check("mid_next_dout", dout, 8'h77);
        check("mid_next_src", out_src, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux2to1.md
Name: stream_mux2to1

Overview:
- Registered 2-to-1 stream merger with valid/ready handshakes on both inputs and on the output.
- Merges two input channels onto one output channel, the inverse of the 1-to-2 demux path.
- Arbitrates between the inputs round-robin and tags each output beat with its source index.
- Keeps per-input accepted-beat counters for debug visibility.

Parameters:
- WIDTH, 8, data width of every channel.
- CNT_W, 8, width of the per-input beat counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- din0  input  WIDTH  channel 0 data.
- valid0  input  1  channel 0 data valid.
- ready0  output  1  channel 0 beat accepted this cycle.
- din1  input  WIDTH  channel 1 data.
- valid1  input  1  channel 1 data valid.
- ready1  output  1  channel 1 beat accepted this cycle.
- dout  output  WIDTH  merged output data, registered.
- out_valid  output  1  dout holds a valid beat.
- out_ready  input  1  downstream accepts the beat this cycle.
- out_src  output  1  source of the current beat: 0 = din0, 1 = din1.
- cnt0  output  CNT_W  beats accepted from channel 0.
- cnt1  output  CNT_W  beats accepted from channel 1.

Behaviour:
- Reset (rst=1 at a posedge):
  - out_valid=0, dout=0, out_src=0, cnt0=0, cnt1=0.
  - Internal last_grant=1, so channel 0 wins the first tie.
  - ready0=ready1=0 while rst=1 (combinational override).
  - Reset mid-transfer discards the held beat and any beat offered that cycle.
- can_accept = !out_valid || out_ready. The output register is empty or drains this cycle.
- Grant (combinational):
  - Only valid0 high: grant 0.
  - Only valid1 high: grant 1.
  - Both high: grant the index != last_grant.
  - Neither high: no grant.
- ready_k = can_accept && grant==k && !rst. At most one ready is high in any cycle. ready_k is never high while valid_k=0.
- A transfer on channel k is valid_k && ready_k at a posedge. On transfer:
  - dout<=din_k, out_src<=k, out_valid<=1.
  - last_grant<=k.
  - cnt_k<=cnt_k+1, wrapping modulo 2^CNT_W with no saturation.
- Output drained (out_valid && out_ready) with no new input transfer: out_valid<=0. dout and out_src keep their last values.
- Drain and accept in the same cycle: the new beat replaces the old one, out_valid stays 1. This gives full throughput of 1 beat/cycle.
- Stall (out_valid && !out_ready):
  - dout, out_src and out_valid are held stable.
  - ready0=ready1=0.
  - last_grant is unchanged, so round-robin order survives backpressure.
- Latency: an input beat accepted at edge N is presented on dout after edge N, i.e. 1 cycle.
- Inputs must hold din_k/valid_k stable until ready_k. The block does not check this.
- Fairness: with both inputs continuously valid and out_ready=1, output sources alternate 0,1,0,1,…

Test Plan:
- Reset: rst=1 for 2 cycles with valid0=valid1=1 -> ready0=ready1=0, out_valid=0, dout=0, cnt0=cnt1=0. After the rst release edge, ready0=1.
- Single channel: valid0=1 with din0=0xA5 for one cycle, out_ready=1 -> next cycle dout=0xA5, out_src=0, out_valid=1, cnt0=1. Cycle after that out_valid=0.
- Round-robin: both valid continuously, din0=0x11, din1=0x22, out_ready=1 for 4 cycles -> dout sequence 0x11,0x22,0x11,0x22, out_src 0,1,0,1, cnt0=2, cnt1=2.
- Backpressure: beat 0x33 from ch1 held, out_ready=0 for 3 cycles with valid0=1 -> dout=0x33 stable, ready0=ready1=0. Then out_ready=1 -> ch0 is accepted in the same cycle and dout=din0 next cycle.
- Counter wrap: 256 back-to-back ch0 beats with CNT_W=8 -> cnt0 returns to 0, cnt1 unchanged.
- Mid-operation reset: out_valid=1 holding 0x5A, out_ready=0, assert rst one cycle -> out_valid=0, counters 0. The next tie is granted to ch0.
